// File: rtl/rsa_axil_slave_regs.sv
// AXI4-Lite register bank for the RSA accelerator: data words, CTRL start
// pulse and STATUS busy/done flags.
module rsa_axil_slave_regs #(
    parameter int C_ADDR_WIDTH    = 5,
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_NUM_DATA_REGS = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [C_ADDR_WIDTH-1:0]                 s_axi_awaddr,
    input  logic [2:0]                              s_axi_awprot,
    input  logic                                    s_axi_awvalid,
    output logic                                    s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]                 s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]               s_axi_wstrb,
    input  logic                                    s_axi_wvalid,
    output logic                                    s_axi_wready,
    output logic [1:0]                              s_axi_bresp,
    output logic                                    s_axi_bvalid,
    input  logic                                    s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]                 s_axi_araddr,
    input  logic [2:0]                              s_axi_arprot,
    input  logic                                    s_axi_arvalid,
    output logic                                    s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]                 s_axi_rdata,
    output logic [1:0]                              s_axi_rresp,
    output logic                                    s_axi_rvalid,
    input  logic                                    s_axi_rready,
    output logic [C_NUM_DATA_REGS*C_DATA_WIDTH-1:0] data_regs_o,
    output logic                                    start_o,
    input  logic                                    core_busy_i,
    input  logic                                    core_done_i
);

    localparam int NB = C_DATA_WIDTH / 8;

    logic                                         run_q;
    logic                                         aw_full;
    logic                                         w_full;
    logic [C_ADDR_WIDTH-1:0]                      aw_addr;
    logic [C_DATA_WIDTH-1:0]                      w_data;
    logic [NB-1:0]                                w_strb;
    logic [C_NUM_DATA_REGS-1:0][C_DATA_WIDTH-1:0] data_q;
    logic                                         done_q;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    commit;
    logic [C_ADDR_WIDTH-1:0] c_addr;
    logic [C_DATA_WIDTH-1:0] c_data;
    logic [NB-1:0]           c_strb;
    logic [2:0]              c_idx;
    logic [2:0]              r_idx;
    logic                    c_err;
    logic                    r_err;
    logic                    do_start;
    logic                    do_clear;
    logic [C_DATA_WIDTH-1:0] rd_val;
    logic                    unused;

    assign unused = ^{s_axi_awprot, s_axi_arprot,
                      s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // run_q keeps every ready low through reset and the edge after it
    assign s_axi_awready = run_q && !aw_full && !s_axi_bvalid;
    assign s_axi_wready  = run_q && !w_full && !s_axi_bvalid;
    assign s_axi_arready = run_q && !s_axi_rvalid;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // A beat arriving this cycle counts as a full holder, so AW+W
    // together commit on the handshake edge
    assign commit = (aw_full || aw_hs) && (w_full || w_hs);
    assign c_addr = aw_full ? aw_addr : s_axi_awaddr;
    assign c_data = w_full ? w_data : s_axi_wdata;
    assign c_strb = w_full ? w_strb : s_axi_wstrb;

    assign c_idx = c_addr[4:2];
    assign r_idx = s_axi_araddr[4:2];
    assign c_err = (c_idx[2:1] == 2'b11);
    assign r_err = (r_idx[2:1] == 2'b11);

    assign do_start = commit && (c_idx == 3'd4) && c_strb[0]
                      && c_data[0] && !core_busy_i;
    assign do_clear = commit && (c_idx == 3'd5) && c_strb[0] && c_data[1];

    assign data_regs_o = data_q;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < C_NUM_DATA_REGS; i++) begin
            if (r_idx == 3'(i)) rd_val = data_q[i];
        end
        if (r_idx == 3'd5) rd_val = {{(C_DATA_WIDTH-2){1'b0}}, done_q, core_busy_i};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q        <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_addr      <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            start_o      <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
        end else begin
            run_q   <= 1'b1;
            start_o <= do_start;

            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= c_err ? 2'b10 : 2'b00;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_addr <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= s_axi_wdata;
                    w_strb <= s_axi_wstrb;
                end
                if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
            end

            for (int i = 0; i < C_NUM_DATA_REGS; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (commit && c_idx == 3'(i) && c_strb[b])
                        data_q[i][8*b +: 8] <= c_data[8*b +: 8];
                end
            end

            // a done pulse beats a same-cycle W1C
            if (core_done_i)   done_q <= 1'b1;
            else if (do_clear) done_q <= 1'b0;

            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= r_err ? 2'b10 : 2'b00;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rsa_axil_slave_regs.sv
// Directed bench for rsa_axil_slave_regs: data words, start pulse,
// W1C done flag, unmapped decode, back-pressure and reset abort.
module tb_rsa_axil_slave_regs;

    logic         clock = 1'b0;
    logic         reset;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] data_regs;
    logic         start;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    rsa_axil_slave_regs dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .data_regs_o   (data_regs),
        .start_o       (start),
        .core_busy_i   (busy),
        .core_done_i   (done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (start) start_cnt++;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bresp_take(output logic [1:0] resp);
        int n = 0;
        while (!bvalid && n < 20) begin
            step(1);
            n++;
        end
        chk("b_arrive", bvalid, 1);
        resp = bresp;
        bready = 1'b1;
        step(1);
        bready = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [1:0] resp);
        logic aw_ok, w_ok;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        while ((awvalid || wvalid) && n < 20) begin
            aw_ok = awvalid && awready;
            w_ok  = wvalid && wready;
            step(1);
            if (aw_ok) awvalid = 1'b0;
            if (w_ok)  wvalid  = 1'b0;
            n++;
        end
        chk("wr_accept", {awvalid, wvalid}, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        bresp_take(resp);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d,
                      output logic [1:0] resp);
        logic ar_ok;
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (arvalid && n < 20) begin
            ar_ok = arready;
            step(1);
            if (ar_ok) arvalid = 1'b0;
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            step(1);
            n++;
        end
        chk("r_arrive", rvalid, 1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        step(1);
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;

        reset = 1'b1; awaddr = '0; awprot = '0; awvalid = 0;
        wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arprot = '0; arvalid = 0; rready = 0;
        busy = 0; done = 0;
        step(3);
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_data", data_regs, 0);
        chk("rst_start", start, 0);
        reset = 1'b0;
        step(1);

        for (int i = 0; i < 4; i++) begin
            wr(5'(4 * i), 32'(i + 1), 4'hF, resp);
            chk("data_bresp", resp, 2'b00);
        end
        for (int i = 0; i < 4; i++) begin
            rd(5'(4 * i), d, resp);
            chk("data_rd", d, 32'(i + 1));
            chk("data_rresp", resp, 2'b00);
        end
        chk("data_flat", data_regs, {32'h4, 32'h3, 32'h2, 32'h1});

        wr(5'h04, 32'h0, 4'hF, resp);
        awaddr = 5'h04; awvalid = 1'b1;
        step(1);
        awvalid = 1'b0;
        chk("aw_held", awready, 0);
        step(2);
        chk("aw_only_nob", bvalid, 0);
        wdata = 32'hA5A5A5A5; wstrb = 4'b0101; wvalid = 1'b1;
        step(1);
        wvalid = 1'b0;
        chk("late_w_bvalid", bvalid, 1);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_bvalid", bvalid, 1);
            chk("stall_bresp", bresp, 2'b00);
            chk("stall_rdy", {awready, wready}, 2'b00);
        end
        bresp_take(resp);
        rd(5'h04, d, resp);
        chk("strb_rd", d, 32'h00A500A5);

        start_cnt = 0;
        wr(5'h10, 32'h1, 4'hF, resp);
        step(3);
        chk("start_once", start_cnt, 1);
        busy = 1'b1;
        start_cnt = 0;
        wr(5'h10, 32'h1, 4'hF, resp);
        step(3);
        chk("start_busy_resp", resp, 2'b00);
        chk("start_busy_none", start_cnt, 0);
        rd(5'h14, d, resp);
        chk("status_busy", d, 32'h1);
        busy = 1'b0;
        rd(5'h10, d, resp);
        chk("ctrl_rd0", d, 32'h0);

        done = 1'b1;
        step(1);
        done = 1'b0;
        rd(5'h14, d, resp);
        chk("done_set", d, 32'h2);
        wr(5'h14, 32'h2, 4'hF, resp);
        rd(5'h14, d, resp);
        chk("done_clr", d, 32'h0);
        chk("pre_race_rdy", {awready, wready}, 2'b11);
        awaddr = 5'h14; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; done = 1'b1;
        step(1);
        awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
        bresp_take(resp);
        rd(5'h14, d, resp);
        chk("done_race", d, 32'h2);

        wr(5'h18, 32'hDEADBEEF, 4'hF, resp);
        chk("unmap_bresp", resp, 2'b10);
        chk("unmap_keep", data_regs,
            {32'h4, 32'h3, 32'h00A500A5, 32'h1});
        rd(5'h1C, d, resp);
        chk("unmap_rdata", d, 32'h0);
        chk("unmap_rresp", resp, 2'b10);

        araddr = 5'h00; arvalid = 1'b1;
        step(1);
        arvalid = 1'b0;
        chk("hold_rvalid", rvalid, 1);
        chk("hold_rdata", rdata, 32'h1);
        reset = 1'b1;
        step(1);
        chk("abort_rvalid", rvalid, 0);
        chk("abort_rdata", rdata, 32'h0);
        reset = 1'b0;
        step(1);
        rd(5'h00, d, resp);
        chk("post_rst_d0", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
